booth_seq_ctrl: RTL and testbench

- FSM controller that sequences one radix-2 Booth multiplication on the existing multiplier datapath.
- Drives the load/enable controls of the operand input registers, clears the accumulator, and issues per-iteration add/subtract/shift commands based on the two Booth bits returned by the datapath.
- Provides a start/busy/done handshake to the surrounding system.

---
 rtl/booth_seq_ctrl.sv | 100 ++++++++++
 tb/tb_booth_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: sequencer for one radix-2 Booth multiply on an external
// datapath (operand load/enable, accumulator clear, add/sub/shift commands).
module booth_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             q0,
  input  logic             qm1,
  output logic             ld_in,
  output logic             en_in,
  output logic             clr_acc,
  output logic             add,
  output logic             sub,
  output logic             shift,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ENABLE,
    S_INIT,
    S_EVAL,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    ld_in       = 1'b0;
    en_in       = 1'b0;
    clr_acc     = 1'b0;
    add         = 1'b0;
    sub         = 1'b0;
    shift       = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        ld_in       = 1'b1;
        w_state_nxt = S_ENABLE;
      end
      S_ENABLE: begin
        en_in       = 1'b1;
        w_state_nxt = S_INIT;
      end
      S_INIT: begin
        clr_acc     = 1'b1;
        w_count_nxt = CNT_W'(WIDTH);
        w_state_nxt = S_EVAL;
      end
      // Booth pair 10 -> subtract, 01 -> add, 00/11 -> no-op
      S_EVAL: begin
        sub         = q0 & ~qm1;
        add         = ~q0 & qm1;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        shift       = 1'b1;
        w_count_nxt = r_count - CNT_W'(1);
        if (r_count == CNT_W'(1)) w_state_nxt = S_DONE;
        else                      w_state_nxt = S_EVAL;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy  = (r_state != S_IDLE);
  assign count = r_count;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb_booth_seq_ctrl: directed checks of the Booth sequencer at WIDTH=16 and 4,
// with a small behavioural datapath to check real products.
module tb_booth_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic st16, st4;
  logic use_m16, use_m4;
  logic fq0_16, fqm1_16, fq0_4, fqm1_4;
  logic q0_16, qm1_16, q0_4, qm1_4;

  logic ld16, en16, clr16, add16, sub16, sh16, busy16, done16;
  logic [4:0] cnt16;
  logic ld4, en4, clr4, add4, sub4, sh4, busy4, done4;
  logic [2:0] cnt4;

  logic [7:0] ctl16, ctl4;
  assign ctl16 = {ld16, en16, clr16, add16, sub16, sh16, busy16, done16};
  assign ctl4  = {ld4, en4, clr4, add4, sub4, sh4, busy4, done4};

  // behavioural datapath, accumulator one bit wider than the operands
  logic [15:0] in_m16, in_q16, h_m16, h_q16, m16, q16;
  logic [16:0] a16;
  logic        qm16;
  logic [3:0]  in_m4, in_q4, h_m4, h_q4, m4, q4;
  logic [4:0]  a4;
  logic        qm4;

  always @(posedge clk) begin
    if (ld16) begin h_m16 <= in_m16; h_q16 <= in_q16; end
    if (en16) begin m16 <= h_m16; q16 <= h_q16; end
    if (clr16) begin a16 <= '0; qm16 <= 1'b0; end
    if (add16) a16 <= a16 + {m16[15], m16};
    if (sub16) a16 <= a16 - {m16[15], m16};
    if (sh16) {a16, q16, qm16} <= {a16[16], a16, q16};
  end

  always @(posedge clk) begin
    if (ld4) begin h_m4 <= in_m4; h_q4 <= in_q4; end
    if (en4) begin m4 <= h_m4; q4 <= h_q4; end
    if (clr4) begin a4 <= '0; qm4 <= 1'b0; end
    if (add4) a4 <= a4 + {m4[3], m4};
    if (sub4) a4 <= a4 - {m4[3], m4};
    if (sh4) {a4, q4, qm4} <= {a4[4], a4, q4};
  end

  assign q0_16  = use_m16 ? q16[0] : fq0_16;
  assign qm1_16 = use_m16 ? qm16   : fqm1_16;
  assign q0_4   = use_m4  ? q4[0]  : fq0_4;
  assign qm1_4  = use_m4  ? qm4    : fqm1_4;

  booth_seq_ctrl #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .start(st16), .q0(q0_16), .qm1(qm1_16),
    .ld_in(ld16), .en_in(en16), .clr_acc(clr16), .add(add16),
    .sub(sub16), .shift(sh16), .busy(busy16), .done(done16),
    .count(cnt16)
  );

  booth_seq_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .start(st4), .q0(q0_4), .qm1(qm1_4),
    .ld_in(ld4), .en_in(en4), .clr_acc(clr4), .add(add4),
    .sub(sub4), .shift(sh4), .busy(busy4), .done(done4),
    .count(cnt4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run16(input logic [15:0] mc, input logic [15:0] mp,
                       output int dcyc, output int ndone,
                       output logic [31:0] prod);
    in_m16 = mc;
    in_q16 = mp;
    use_m16 = 1'b1;
    st16 = 1'b1;
    dcyc = -1;
    ndone = 0;
    @(posedge clk); #1;
    st16 = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done16) begin
        ndone++;
        if (dcyc < 0) dcyc = c;
      end
      @(posedge clk); #1;
    end
    prod = {a16[15:0], q16};
  endtask

  typedef struct packed {
    logic       st;
    logic       q0;
    logic       qm1;
    logic [7:0] ctl;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int dc, nd, nsh, ld1, ld2;
    logic [31:0] prod;
    logic [7:0]  exp_ctl;
    logic [4:0]  exp_cnt;
    logic [1:0]  seq[4];
    logic [1:0]  exp_seq[4];

    // ctl = {ld,en,clr,add,sub,shift,busy,done}
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'b0000_0000, 3'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'b1000_0010, 3'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'b0100_0010, 3'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'b0010_0010, 3'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'b0000_1010, 3'd4};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'b0000_0110, 3'd4};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'b0001_0010, 3'd3};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'b0000_0110, 3'd3};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'b0000_0010, 3'd2};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'b0000_0110, 3'd2};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'b0000_0010, 3'd1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'b0000_0110, 3'd1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 8'b0000_0011, 3'd0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'b0000_0000, 3'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'b0000_0000, 3'd0};

    exp_seq[0] = 2'b01;
    exp_seq[1] = 2'b00;
    exp_seq[2] = 2'b10;
    exp_seq[3] = 2'b01;

    reset = 1'b0;
    st16 = 1'b1;
    st4 = 1'b1;
    use_m16 = 1'b0;
    use_m4 = 1'b0;
    fq0_16 = 1'b0; fqm1_16 = 1'b0;
    fq0_4 = 1'b0;  fqm1_4 = 1'b0;
    in_m16 = '0; in_q16 = '0;
    in_m4 = '0;  in_q4 = '0;

    // reset held with start high
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ctl16", ctl16, 8'h00);
      chk("rst_cnt16", cnt16, 5'd0);
      chk("rst_ctl4", ctl4, 8'h00);
      @(posedge clk);
    end
    #1;
    reset = 1'b1;
    st16 = 1'b0;
    st4 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("post_rst_ctl16", ctl16, 8'h00);
      chk("post_rst_cnt16", cnt16, 5'd0);
      @(posedge clk); #1;
    end

    // WIDTH=4 table with directly driven Booth bits
    for (int i = 0; i < 15; i++) begin
      st4 = vecs[i].st;
      fq0_4 = vecs[i].q0;
      fqm1_4 = vecs[i].qm1;
      @(negedge clk);
      chk($sformatf("tbl4_ctl[%0d]", i), ctl4, vecs[i].ctl);
      chk($sformatf("tbl4_cnt[%0d]", i), cnt4, vecs[i].cnt);
      @(posedge clk); #1;
    end
    st4 = 1'b0;

    // WIDTH=16, Booth bits 00, stray starts at 5, 20 and DONE
    fq0_16 = 1'b0;
    fqm1_16 = 1'b0;
    st16 = 1'b1;
    @(posedge clk); #1;
    nd = 0;
    nsh = 0;
    for (int c = 1; c <= 38; c++) begin
      st16 = (c == 5) || (c == 20) || (c == 36);
      exp_ctl = 8'h00;
      exp_cnt = 5'd0;
      if (c == 1) exp_ctl = 8'b1000_0010;
      else if (c == 2) exp_ctl = 8'b0100_0010;
      else if (c == 3) exp_ctl = 8'b0010_0010;
      else if (c >= 4 && c <= 35) begin
        exp_cnt = 5'(16 - (c - 4) / 2);
        exp_ctl = (c % 2 == 0) ? 8'b0000_0010 : 8'b0000_0110;
      end else if (c == 36) exp_ctl = 8'b0000_0011;
      @(negedge clk);
      chk($sformatf("op16_ctl[c%0d]", c), ctl16, exp_ctl);
      chk($sformatf("op16_cnt[c%0d]", c), cnt16, exp_cnt);
      if ($countones({ld16, en16, clr16, add16, sub16, sh16}) > 1)
        chk($sformatf("op16_mutex[c%0d]", c), 1, 0);
      if (done16) nd++;
      if (sh16) nsh++;
      @(posedge clk); #1;
    end
    st16 = 1'b0;
    chk("op16_done_count", nd, 1);
    chk("op16_shift_count", nsh, 16);

    // start held high: LOAD again two cycles after DONE
    st16 = 1'b1;
    @(posedge clk); #1;
    ld1 = -1;
    ld2 = -1;
    dc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ld16) begin
        if (ld1 < 0) ld1 = c;
        else if (ld2 < 0) ld2 = c;
      end
      if (done16 && dc < 0) dc = c;
      @(posedge clk); #1;
    end
    st16 = 1'b0;
    chk("b2b_first_load", ld1, 1);
    chk("b2b_done", dc, 36);
    chk("b2b_second_load", ld2, 38);
    for (int c = 0; c < 80 && busy16; c++) begin
      @(posedge clk); #1;
    end
    chk("b2b_drain_busy", busy16, 1'b0);

    // WIDTH=4 Booth with datapath: 3 x -5
    use_m4 = 1'b1;
    in_m4 = 4'd3;
    in_q4 = 4'b1011;
    st4 = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0;
    dc = -1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c >= 4 && c <= 10 && c % 2 == 0) seq[(c - 4) / 2] = {add4, sub4};
      if (done4 && dc < 0) dc = c;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++)
      chk($sformatf("booth4_addsub[%0d]", k), seq[k], exp_seq[k]);
    chk("booth4_product", {a4[3:0], q4}, 8'hF1);
    chk("booth4_done_cycle", dc, 12);

    // WIDTH=16 boundary operands
    run16(16'h8000, 16'h8000, dc, nd, prod);
    chk("min_x_min_product", prod, 32'h4000_0000);
    chk("min_x_min_done", dc, 36);
    run16(16'h7FFF, 16'h7FFF, dc, nd, prod);
    chk("max_x_max_product", prod, 32'h3FFF_0001);
    chk("max_x_max_ndone", nd, 1);

    // asynchronous reset in cycle 10 (EVAL)
    use_m16 = 1'b0;
    st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("abort_pre_eval_busy", busy16, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_ctl16", ctl16, 8'h00);
    chk("abort_cnt16", cnt16, 5'd0);
    nd = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (done16) nd++;
      @(posedge clk);
    end
    #1;
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done16 || busy16) nd++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", nd, 0);

    run16(16'h1234, 16'hFFFF, dc, nd, prod);
    chk("post_abort_product", prod, 32'hFFFF_EDCC);
    chk("post_abort_done", dc, 36);
    chk("post_abort_ndone", nd, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
